// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// aes_pkg : shared encodings, per-key-size constants and GF(2^8) helpers
//           for the AES key-schedule controller.
// Rev 1.0
// ============================================================================
package aes_pkg;

  typedef enum logic [1:0] {
    KS_128  = 2'd0,
    KS_192  = 2'd1,
    KS_256  = 2'd2,
    KS_RSVD = 2'd3
  } key_size_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    EXPAND = 3'd2,
    READY  = 3'd3,
    ZERO   = 3'd4
  } state_e;

  localparam int AES_MAX_WORDS = 60;

  localparam logic [3:0] NK_128 = 4'd4;
  localparam logic [3:0] NK_192 = 4'd6;
  localparam logic [3:0] NK_256 = 4'd8;

  localparam logic [3:0] NR_128 = 4'd10;
  localparam logic [3:0] NR_192 = 4'd12;
  localparam logic [3:0] NR_256 = 4'd14;

  localparam logic [5:0] NW_128 = 6'd44;
  localparam logic [5:0] NW_192 = 6'd52;
  localparam logic [5:0] NW_256 = 6'd60;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_sbox_word.sv
`default_nettype none
// ============================================================================
// aes_sbox_word : combinational SubWord, four AES S-box lookups computed as
//                 GF(2^8) inverse followed by the affine transform.
// Rev 1.0
// ============================================================================
module aes_sbox_word
  import aes_pkg::*;
(
  input  logic [31:0] din,
  output logic [31:0] dout
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // x^254 == x^-1 for nonzero x, and maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = a;
    for (int k = 1; k < 8; k++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox_byte(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^
           {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  generate
    for (genvar g = 0; g < 4; g++) begin : g_byte
      assign dout[8*g +: 8] = sbox_byte(din[8*g +: 8]);
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/aes_key_sched_ctrl.sv
`default_nettype none
// ============================================================================
// aes_key_sched_ctrl : AES-128/192/256 key expansion sequencer with a 60-word
//                      round-key buffer and request/valid round-key port.
//                      Optional buffer zeroize: define AES_KEY_ZEROIZE_EN.
// Rev 1.0
// ============================================================================
module aes_key_sched_ctrl
  import aes_pkg::*;
#(
  parameter int MAX_WORDS = AES_MAX_WORDS,
  parameter int RK_IDX_W  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [1:0]          key_size,
  input  logic [255:0]        key_in,
`ifdef AES_KEY_ZEROIZE_EN
  input  logic                zeroize,
`endif
  output logic                busy,
  output logic                done,
  output logic                cfg_err,
  input  logic                rk_req,
  input  logic [RK_IDX_W-1:0] rk_idx,
  output logic                rk_valid,
  output logic [127:0]        rk_out,
  output logic                rk_err
);

  state_e              state, state_nxt;
  logic [255:0]        key_q;
  logic [3:0]          nk;
  logic [RK_IDX_W-1:0] nr;
  logic [5:0]          nw_last;
  logic [5:0]          wcnt;
  logic [2:0]          kpos;
  logic [7:0]          rcon;
  logic [5:0]          zcnt;
  logic [31:0]         words [MAX_WORDS];

  logic                zero_req;
  logic                start_ok;
  logic                start_bad;
  logic [31:0]         prev_word;
  logic [31:0]         sbox_in;
  logic [31:0]         sbox_out;
  logic [31:0]         temp;
  logic [31:0]         new_word;

`ifdef AES_KEY_ZEROIZE_EN
  assign zero_req = zeroize;
`else
  assign zero_req = 1'b0;
`endif

  assign start_ok  = start && (key_size != KS_RSVD) && !zero_req &&
                     ((state == IDLE) || (state == READY));
  assign start_bad = start && (key_size == KS_RSVD) && !zero_req &&
                     ((state == IDLE) || (state == READY));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    if (zero_req) begin
      state_nxt = ZERO;
    end else begin
      case (state)
        IDLE:    if (start_ok) state_nxt = LOAD;
        LOAD:    state_nxt = EXPAND;
        EXPAND:  if (wcnt == nw_last) state_nxt = READY;
        READY:   if (start_ok) state_nxt = LOAD;
        ZERO:    if (zcnt == 6'(MAX_WORDS - 1)) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
    busy = (state == LOAD) || (state == EXPAND) || (state == ZERO);
  end

  // kpos tracks i mod Nk so no divider is needed for Nk = 6.
  always_comb begin
    prev_word = words[wcnt - 6'd1];
    sbox_in   = (kpos == 3'd0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;
    if (kpos == 3'd0)                        temp = sbox_out ^ {rcon, 24'h000000};
    else if (nk == NK_256 && kpos == 3'd4)   temp = sbox_out;
    else                                     temp = prev_word;
    new_word  = words[wcnt - {2'b00, nk}] ^ temp;
  end

  aes_sbox_word u_sbox (
    .din  (sbox_in),
    .dout (sbox_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      done     <= 1'b0;
      cfg_err  <= 1'b0;
      rk_valid <= 1'b0;
      rk_err   <= 1'b0;
      rk_out   <= '0;
      wcnt     <= '0;
      kpos     <= '0;
      rcon     <= 8'h01;
      zcnt     <= '0;
      key_q    <= '0;
      nk       <= NK_128;
      nr       <= RK_IDX_W'(NR_128);
      nw_last  <= NW_128 - 6'd1;
    end else begin
      done     <= 1'b0;
      cfg_err  <= start_bad;
      rk_valid <= 1'b0;
      rk_err   <= 1'b0;
      if (zero_req) begin
        zcnt <= '0;
      end else if (start_ok) begin
        key_q <= key_in;
        wcnt  <= '0;
        kpos  <= '0;
        rcon  <= 8'h01;
        case (key_size)
          KS_192: begin nk <= NK_192; nr <= RK_IDX_W'(NR_192); nw_last <= NW_192 - 6'd1; end
          KS_256: begin nk <= NK_256; nr <= RK_IDX_W'(NR_256); nw_last <= NW_256 - 6'd1; end
          default: begin nk <= NK_128; nr <= RK_IDX_W'(NR_128); nw_last <= NW_128 - 6'd1; end
        endcase
      end else begin
        case (state)
          LOAD: wcnt <= {2'b00, nk};
          EXPAND: begin
            wcnt <= wcnt + 6'd1;
            kpos <= ({1'b0, kpos} == nk - 4'd1) ? 3'd0 : kpos + 3'd1;
            if (kpos == 3'd0) rcon <= xtime(rcon);
            if (wcnt == nw_last) done <= 1'b1;
          end
          READY: begin
            if (rk_req) begin
              if (rk_idx > nr) begin
                rk_err <= 1'b1;
              end else begin
                rk_valid <= 1'b1;
                rk_out   <= {words[{rk_idx, 2'd0}], words[{rk_idx, 2'd1}],
                             words[{rk_idx, 2'd2}], words[{rk_idx, 2'd3}]};
              end
            end
          end
          ZERO:    zcnt <= zcnt + 6'd1;
          default: ;
        endcase
      end
    end
  end

  // Buffer has no reset; contents only matter once READY is reached.
  always_ff @(posedge clk) begin
    if (!rst && !zero_req && !start_ok) begin
      if (state == LOAD) begin
        for (int k = 0; k < 8; k++) words[k] <= key_q[255 - 32*k -: 32];
      end else if (state == EXPAND) begin
        words[wcnt] <= new_word;
      end else if (state == ZERO) begin
        words[zcnt] <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aes_key_sched_ctrl.sv
`default_nettype none
// ============================================================================
// tb_aes_key_sched_ctrl : self-checking bench with an independent
//                         FIPS-197 key-expansion reference model.
// Rev 1.0
// ============================================================================
module tb_aes_key_sched_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   key_size = 2'd0;
  logic [255:0] key_in = '0;
  logic         rk_req = 1'b0;
  logic [3:0]   rk_idx = 4'd0;
  logic         busy, done, cfg_err, rk_valid, rk_err;
  logic [127:0] rk_out;
`ifdef AES_KEY_ZEROIZE_EN
  logic         zeroize = 1'b0;
`endif

  int checks = 0;
  int failures = 0;

  logic [7:0]  sbox_t [256];
  logic [31:0] mw [60];
  logic [7:0]  rcon_t [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                               8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  aes_key_sched_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .key_size (key_size),
    .key_in   (key_in),
`ifdef AES_KEY_ZEROIZE_EN
    .zeroize  (zeroize),
`endif
    .busy     (busy),
    .done     (done),
    .cfg_err  (cfg_err),
    .rk_req   (rk_req),
    .rk_idx   (rk_idx),
    .rk_valid (rk_valid),
    .rk_out   (rk_out),
    .rk_err   (rk_err)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] aa;
    logic [7:0] p;
    p  = 8'h00;
    aa = {1'b0, a};
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ aa[7:0];
      aa = aa << 1;
      if (aa[8]) aa = aa ^ 9'h11b;
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] c;
    logic [7:0] s;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sbox_t[x] = s;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  task automatic model_expand(input logic [255:0] key, input int nk);
    logic [31:0] t;
    int nw;
    nw = 4 * (nk + 7);
    for (int i = 0; i < nk; i++) mw[i] = key[255 - 32*i -: 32];
    for (int i = nk; i < nw; i++) begin
      t = mw[i-1];
      if (i % nk == 0)               t = subw({t[23:0], t[31:24]}) ^ {rcon_t[i/nk - 1], 24'h0};
      else if (nk > 6 && i % nk == 4) t = subw(t);
      mw[i] = mw[i-nk] ^ t;
    end
  endtask

  function automatic logic [127:0] model_rk(input int k);
    return {mw[4*k], mw[4*k+1], mw[4*k+2], mw[4*k+3]};
  endfunction

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulses start; returns the edge number (start edge = 0) after which done was seen, or -1.
  task automatic do_load(input logic [255:0] key, input logic [1:0] ks, output int edge_n);
    start = 1'b1; key_size = ks; key_in = key;
    tick();
    start = 1'b0;
    edge_n = -1;
    for (int n = 1; n <= 120; n++) begin
      tick();
      if (done === 1'b1) begin edge_n = n; break; end
    end
  endtask

  task automatic read_rk(input logic [3:0] idx, output logic v, output logic e, output logic [127:0] o);
    rk_req = 1'b1; rk_idx = idx;
    tick();
    rk_req = 1'b0;
    v = rk_valid; e = rk_err; o = rk_out;
  endtask

  function automatic logic [255:0] rand_key();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [5:0] obs;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    obs = {busy, done, cfg_err, rk_valid, rk_err, |rk_out};
    checks++;
    if (obs !== 6'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=000000", obs);
    end
    rk_req = 1'b1; rk_idx = 4'd0;
    tick();
    rk_req = 1'b0;
    checks++;
    if ({rk_valid, rk_err} !== 2'b00) begin
      failures++;
      $display("FAIL idle_rk_req got=%b exp=00", {rk_valid, rk_err});
    end
  endtask

  task automatic test_cfg_err();
    start = 1'b1; key_size = 2'b11; key_in = rand_key();
    tick();
    start = 1'b0;
    checks++;
    if ({cfg_err, busy} !== 2'b10) begin
      failures++;
      $display("FAIL cfg_err_pulse got=%b exp=10", {cfg_err, busy});
    end
    tick();
    checks++;
    if ({cfg_err, busy, done} !== 3'b000) begin
      failures++;
      $display("FAIL cfg_err_one_cycle got=%b exp=000", {cfg_err, busy, done});
    end
  endtask

  task automatic test_aes128_vectors();
    int e; logic v, er; logic [127:0] o;
    logic [255:0] k;
    k = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    do_load(k, 2'b00, e);
    checks++;
    if (e != 41) begin failures++; $display("FAIL aes128_done_edge got=%0d exp=41", e); end
    tick();
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL aes128_done_width got=%b exp=0", done); end
    read_rk(4'd1, v, er, o);
    checks++;
    if ({v, er, o} !== {2'b10, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe}) begin
      failures++; $display("FAIL aes128_rk1 got=%b%b %h exp=10 d6aa74fdd2af72fadaa678f1d6ab76fe", v, er, o);
    end
    read_rk(4'd10, v, er, o);
    checks++;
    if ({v, er, o} !== {2'b10, 128'h13111d7fe3944a17f307a78b4d2b30c5}) begin
      failures++; $display("FAIL aes128_rk10 got=%b%b %h exp=10 13111d7fe3944a17f307a78b4d2b30c5", v, er, o);
    end
  endtask

  task automatic test_aes192_vectors();
    int e; logic v, er; logic [127:0] o;
    logic [255:0] k;
    k = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    do_load(k, 2'b01, e);
    checks++;
    if (e != 47) begin failures++; $display("FAIL aes192_done_edge got=%0d exp=47", e); end
    read_rk(4'd12, v, er, o);
    checks++;
    if ({v, er, o} !== {2'b10, 128'ha4970a331a78dc09c418c271e3a41d5d}) begin
      failures++; $display("FAIL aes192_rk12 got=%b%b %h exp=10 a4970a331a78dc09c418c271e3a41d5d", v, er, o);
    end
    read_rk(4'd13, v, er, o);
    checks++;
    if ({v, er, o} !== {2'b01, 128'ha4970a331a78dc09c418c271e3a41d5d}) begin
      failures++; $display("FAIL aes192_rk13_err got=%b%b %h exp=01 a4970a331a78dc09c418c271e3a41d5d", v, er, o);
    end
  endtask

  task automatic test_aes256_vectors();
    int e; logic v, er; logic [127:0] o;
    do_load(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 2'b10, e);
    checks++;
    if (e != 53) begin failures++; $display("FAIL aes256_done_edge got=%0d exp=53", e); end
    read_rk(4'd1, v, er, o);
    checks++;
    if ({v, er, o} !== {2'b10, 128'h101112131415161718191a1b1c1d1e1f}) begin
      failures++; $display("FAIL aes256_rk1 got=%b%b %h exp=10 101112131415161718191a1b1c1d1e1f", v, er, o);
    end
    read_rk(4'd14, v, er, o);
    checks++;
    if ({v, er, o} !== {2'b10, 128'h24fc79ccbf0979e9371ac23c6d68de36}) begin
      failures++; $display("FAIL aes256_rk14 got=%b%b %h exp=10 24fc79ccbf0979e9371ac23c6d68de36", v, er, o);
    end
  endtask

  task automatic test_expand_ignores();
    logic [255:0] k; int e; logic v, er; logic [127:0] o;
    logic resp;
    k = rand_key();
    model_expand(k, 4);
    start = 1'b1; key_size = 2'b00; key_in = k;
    tick();
    start = 1'b0;
    e = -1; resp = 1'b0;
    for (int n = 1; n <= 120; n++) begin
      if (n == 10) begin start = 1'b1; key_size = 2'b10; key_in = ~k; rk_req = 1'b1; rk_idx = 4'd0; end
      tick();
      if (n == 10) begin
        start = 1'b0; rk_req = 1'b0;
        resp = rk_valid | rk_err;
      end
      if (done === 1'b1) begin e = n; break; end
    end
    checks++;
    if (resp !== 1'b0) begin failures++; $display("FAIL expand_rk_req_ignored got=%b exp=0", resp); end
    checks++;
    if (e != 41) begin failures++; $display("FAIL expand_start_ignored_edge got=%0d exp=41", e); end
    read_rk(4'd10, v, er, o);
    checks++;
    if ({v, er, o} !== {2'b10, model_rk(10)}) begin
      failures++; $display("FAIL expand_start_ignored_rk10 got=%b%b %h exp=10 %h", v, er, o, model_rk(10));
    end
  endtask

  task automatic test_rst_mid();
    logic [255:0] k; int e; logic v, er; logic [127:0] o;
    int n_done, n_resp;
    start = 1'b1; key_size = 2'b00; key_in = rand_key();
    tick();
    start = 1'b0;
    for (int n = 1; n <= 17; n++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
    n_done = 0; n_resp = 0;
    rk_req = 1'b1; rk_idx = 4'd0;
    for (int n = 0; n < 50; n++) begin
      tick();
      if (done === 1'b1) n_done++;
      if (rk_valid === 1'b1 || rk_err === 1'b1) n_resp++;
    end
    rk_req = 1'b0;
    checks++;
    if (n_done != 0 || n_resp != 0) begin
      failures++; $display("FAIL rst_mid_quiet got=done:%0d resp:%0d exp=0,0", n_done, n_resp);
    end
    k = rand_key();
    model_expand(k, 4);
    do_load(k, 2'b00, e);
    checks++;
    if (e != 41) begin failures++; $display("FAIL rst_restart_edge got=%0d exp=41", e); end
    read_rk(4'd10, v, er, o);
    checks++;
    if ({v, er, o} !== {2'b10, model_rk(10)}) begin
      failures++; $display("FAIL rst_restart_rk10 got=%b%b %h exp=10 %h", v, er, o, model_rk(10));
    end
  endtask

  task automatic test_back_to_back();
    logic [255:0] k; int e;
    k = rand_key();
    model_expand(k, 4);
    do_load(k, 2'b00, e);
    rk_req = 1'b1; rk_idx = 4'd0;
    for (int i = 0; i <= 10; i++) begin
      tick();
      if (i < 10) rk_idx = 4'(i + 1);
      else        rk_req = 1'b0;
      checks++;
      if ({rk_valid, rk_err, rk_out} !== {2'b10, model_rk(i)}) begin
        failures++; $display("FAIL b2b_rk%0d got=%b%b %h exp=10 %h", i, rk_valid, rk_err, rk_out, model_rk(i));
      end
    end
    tick();
    checks++;
    if (rk_valid !== 1'b0) begin failures++; $display("FAIL b2b_valid_drop got=%b exp=0", rk_valid); end
  endtask

  task automatic test_random();
    logic [255:0] k; logic [1:0] ks; int nk, nr, e; logic v, er; logic [127:0] o;
    logic [127:0] last;
    logic [3:0] idx;
    for (int t = 0; t < 6; t++) begin
      ks = 2'($urandom_range(0, 2));
      nk = 4 + 2 * int'(ks);
      nr = nk + 6;
      k  = rand_key();
      model_expand(k, nk);
      do_load(k, ks, e);
      checks++;
      if (e != 4 * (nr + 1) - nk + 1) begin
        failures++; $display("FAIL rand%0d_done_edge got=%0d exp=%0d", t, e, 4 * (nr + 1) - nk + 1);
      end
      read_rk(4'd0, v, er, o);
      last = o;
      for (int r = 0; r < 8; r++) begin
        idx = 4'($urandom_range(0, 15));
        read_rk(idx, v, er, o);
        checks++;
        if (int'(idx) <= nr) begin
          if ({v, er, o} !== {2'b10, model_rk(int'(idx))}) begin
            failures++; $display("FAIL rand%0d_rk%0d got=%b%b %h exp=10 %h", t, idx, v, er, o, model_rk(int'(idx)));
          end
          last = model_rk(int'(idx));
        end else if ({v, er, o} !== {2'b01, last}) begin
          failures++; $display("FAIL rand%0d_err%0d got=%b%b %h exp=01 %h", t, idx, v, er, o, last);
        end
      end
    end
  endtask

`ifdef AES_KEY_ZEROIZE_EN
  task automatic test_zeroize();
    logic [255:0] k; int e, cnt, resp; logic v, er; logic [127:0] o;
    do_load(rand_key(), 2'b10, e);
    rk_req = 1'b1; rk_idx = 4'd0;
    zeroize = 1'b1;
    tick();
    zeroize = 1'b0;
    cnt = 0; resp = 0;
    while (busy === 1'b1 && cnt < 200) begin
      cnt++;
      if (rk_valid === 1'b1 || rk_err === 1'b1) resp++;
      tick();
    end
    rk_req = 1'b0;
    checks++;
    if (cnt != 60) begin failures++; $display("FAIL zero_busy_cycles got=%0d exp=60", cnt); end
    checks++;
    if (resp != 0) begin failures++; $display("FAIL zero_rk_req_ignored got=%0d exp=0", resp); end
    k = rand_key();
    model_expand(k, 4);
    do_load(k, 2'b00, e);
    checks++;
    if (e != 41) begin failures++; $display("FAIL zero_reload_edge got=%0d exp=41", e); end
    for (int i = 0; i <= 10; i++) begin
      read_rk(4'(i), v, er, o);
      checks++;
      if ({v, er, o} !== {2'b10, model_rk(i)}) begin
        failures++; $display("FAIL zero_reload_rk%0d got=%b%b %h exp=10 %h", i, v, er, o, model_rk(i));
      end
    end
  endtask
`endif

  initial begin
    build_sbox();
    test_reset();
    test_cfg_err();
    test_aes128_vectors();
    test_aes192_vectors();
    test_aes256_vectors();
    test_expand_ignores();
    test_rst_mid();
    test_back_to_back();
    test_random();
`ifdef AES_KEY_ZEROIZE_EN
    test_zeroize();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/aes_key_sched_ctrl.md
Name: aes_key_sched_ctrl

Overview:
Sequencing controller for AES key expansion. It generates one 32-bit key-schedule word per cycle for AES-128, AES-192 or AES-256. Words go into an internal 60-word round-key buffer, and the controller then serves full 128-bit round keys to the cipher round engine through a request/valid handshake. It sits between the key-load interface and the round datapath, and owns the only S-box instance used for the key schedule.

Parameters:
MAX_WORDS, 60, depth of round-key word buffer (4*(14+1)); fixed for AES-256 worst case.
RK_IDX_W, 4, width of round-key index (covers 0..14).

Ports:
clk  input  1  clock
rst  input  1  reset: synchronous, active-high
start  input  1  one-cycle pulse; begin expansion of key_in
key_size  input  2  00=AES-128, 01=AES-192, 10=AES-256, 11=reserved
key_in  input  256  cipher key, MSB-aligned; word0 = key_in[255:224]; AES-128 uses [255:128], AES-192 uses [255:64]
busy  output  1  high in LOAD/EXPAND (and ZERO if enabled)
done  output  1  one-cycle pulse on entry to READY
cfg_err  output  1  one-cycle pulse when start is seen with key_size=11
rk_req  input  1  round-key read request
rk_idx  input  4  round-key number, 0..Nr
rk_valid  output  1  read response strobe, one cycle
rk_out  output  128  round key {w[4k],w[4k+1],w[4k+2],w[4k+3]}
rk_err  output  1  one-cycle pulse: rk_idx > Nr of the loaded key

Behaviour:
- Nk/Nr/Nw by key size: 128: 4/10/44; 192: 6/12/52; 256: 8/14/60. Nk and Nr are latched at start.
- Reset: state=IDLE; busy, done, cfg_err, rk_valid, rk_err = 0; rk_out = 0; word counter = 0; rcon = 8'h01. Buffer contents are don't-care.
- IDLE:
  - start with a valid key_size -> LOAD; latch key_in, Nk, Nr.
  - start with key_size=11 -> cfg_err pulse next cycle; stay IDLE.
- LOAD (1 cycle): write w[0..Nk-1] from the latched key; set i=Nk; -> EXPAND.
- EXPAND (one word per cycle, i = Nk..Nw-1):
  - temp = w[i-1].
  - If i mod Nk == 0: temp = SubWord(RotWord(temp)) ^ {rcon,24'h0}, then rcon = xtime(rcon), giving 01,02,04,08,10,20,40,80,1b,36.
  - Else if Nk == 8 and i mod 8 == 4: temp = SubWord(temp).
  - w[i] = w[i-Nk] ^ temp.
  - After w[Nw-1] is written -> READY with done=1.
- Latency: counting the edge that samples start as edge 0, done is high after edge 41 (128), 47 (192) or 53 (256).
- READY:
  - rk_req with rk_idx <= Nr -> next cycle rk_valid=1 with rk_out = round key rk_idx.
  - rk_req with rk_idx > Nr -> next cycle rk_err=1, rk_valid=0, rk_out unchanged.
  - Back-to-back requests supported, one per cycle.
  - start in READY -> new key load; READY and its contents are abandoned.
- rk_req outside READY: ignored; no rk_valid and no rk_err.
- start in LOAD/EXPAND: ignored; the running expansion completes.
- rst mid-expansion: immediate return to IDLE on that edge; no done; a later rk_req gets no response until a new expansion completes.
- Counter i and rcon are cleared on every entry to LOAD.

Optional Feature:
- Macro AES_KEY_ZEROIZE_EN.
- Defined:
  - Adds input port zeroize (1 bit).
  - zeroize in any non-reset state -> ZERO state, which clears one buffer word per cycle for 60 cycles with busy=1, then -> IDLE.
  - zeroize has priority over start and rk_req.
  - zeroize during ZERO restarts the count.
- Not defined: port absent, no ZERO state, buffer retains contents until overwritten.

Decomposition:
- Package aes_pkg holds:
  - key_size encodings and state enum (IDLE, LOAD, EXPAND, READY, ZERO);
  - NK/NR/NW constants per key size and the MAX_WORDS constant;
  - the xtime function.
- One sub-module, aes_sbox_word: combinational 4-byte S-box lookup (SubWord), instantiated once.

Test Plan:
- AES-128, key 000102..0f -> done after edge 41; rk_idx=1 -> d6aa74fdd2af72fadaa678f1d6ab76fe; rk_idx=10 -> 13111d7fe3944a17f307a78b4d2b30c5.
- AES-192, key 000102..17 -> done after edge 47; rk_idx=12 -> a4970a331a78dc09c418c271e3a41d5d; rk_idx=13 -> rk_err pulse, no rk_valid.
- AES-256, key 000102..1f -> done after edge 53; rk_idx=1 -> 101112131415161718191a1b1c1d1e1f; rk_idx=14 -> 24fc79ccbf0979e9371ac23c6d68de36.
- key_size=11 with start -> cfg_err pulse, busy stays 0, state IDLE; rk_req during EXPAND -> no response; start during EXPAND -> ignored, original done timing preserved.
- rst asserted at EXPAND word 20, then AES-128 restart -> no done before restart; correct rk10 after restart. Back-to-back rk_req idx 0..10 -> 11 consecutive rk_valid cycles.
- (AES_KEY_ZEROIZE_EN) zeroize in READY -> busy 60 cycles then IDLE; after a new AES-128 load, all keys correct; rk_req during ZERO -> ignored.
